// File: rtl/pwm_timer.sv
// pwm_timer: NCH-channel PWM/timer on the picorv32 native bus (prescaler, shared period, per-channel duty, sticky wrap flag).
// Latency: rdy one clock after cs (single wait state); pwm registered one clock after cnt; wrap pulse registered.
// Backpressure: none internally; the master holds cs until rdy. Define PWM_SHADOW_EN for double-buffered PERIOD/DUTY.
module pwm_timer #(
    parameter int NCH = 4,
    parameter int CW  = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cs,
    input  logic           we,
    input  logic [3:0]     addr,
    input  logic [31:0]    din,
    output logic [31:0]    dout,
    output logic           rdy,
    output logic [NCH-1:0] pwm,
    output logic           wrap
);

    // Word offsets of the register map; DUTY[n] lives at A_DUTY0 + n.
    localparam logic [3:0] A_CTRL   = 4'd0;
    localparam logic [3:0] A_PRESC  = 4'd1;
    localparam logic [3:0] A_PERIOD = 4'd2;
    localparam logic [3:0] A_STATUS = 4'd3;
    localparam logic [3:0] A_DUTY0  = 4'd4;

    // Bus handshake
    logic                     rdy_q, rdy_d;
    logic                     wr_commit;

    // Software-visible registers
    logic                     en_q, en_d;
    logic [CW-1:0]            presc_q, presc_d;
    logic [CW-1:0]            period_q, period_d;
    logic                     wrapf_q, wrapf_d;
    logic [NCH-1:0][CW-1:0]   duty_q, duty_d;

    // Timebase and outputs
    logic [CW-1:0]            presc_cnt_q, presc_cnt_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [NCH-1:0]           pwm_q, pwm_d;
    logic                     wrap_q, wrap_d;

    // Values actually used by the comparators (aliases or shadow copies)
    logic [CW-1:0]            period_act;
    logic [NCH-1:0][CW-1:0]   duty_act;

    logic                     clr;
    logic                     presc_hit;
    logic                     tick;
    logic                     wrap_evt;
    logic [CW-1:0]            din_w;
    logic                     unused_din;

    assign din_w      = din[CW-1:0];
    assign unused_din = ^din[31:CW];

    // One-wait-state handshake: a write commits only on the first cycle of cs.
    always_comb begin
        rdy_d     = cs & ~rdy_q;
        wr_commit = cs & we & ~rdy_q;
    end

    // Register-file writes; CLR is a write-1 strobe that is never stored.
    always_comb begin
        en_d     = en_q;
        presc_d  = presc_q;
        period_d = period_q;
        duty_d   = duty_q;
        clr      = 1'b0;
        if (wr_commit) begin
            case (addr)
                A_CTRL: begin
                    en_d = din[0];
                    clr  = din[1];
                end
                A_PRESC:  presc_d  = din_w;
                A_PERIOD: period_d = din_w;
                default: ;
            endcase
            for (int n = 0; n < NCH; n++) begin
                if (addr == A_DUTY0 + 4'(n)) begin
                    duty_d[n] = din_w;
                end
            end
        end
    end

    // A tick is one prescaled count step; CLR overrides it on the same clock.
    assign presc_hit = (presc_cnt_q == presc_q);
    assign tick      = en_q & presc_hit & ~clr;
    assign wrap_evt  = tick & (cnt_q == period_act);

    // Prescaler and main counter. A counter above a freshly lowered PERIOD
    // simply runs on and rolls over mod 2^CW without signalling a wrap.
    always_comb begin
        presc_cnt_d = presc_cnt_q;
        cnt_d       = cnt_q;
        if (clr) begin
            presc_cnt_d = '0;
            cnt_d       = '0;
        end else if (en_q) begin
            presc_cnt_d = presc_hit ? '0 : presc_cnt_q + CW'(1);
            if (tick) begin
                cnt_d = wrap_evt ? '0 : cnt_q + CW'(1);
            end
        end
    end

    // Sticky wrap flag: a wrap on the same clock as a clear leaves it set.
    always_comb begin
        wrapf_d = wrapf_q;
        if (wr_commit && (addr == A_STATUS) && din[0]) begin
            wrapf_d = 1'b0;
        end
        if (wrap_evt) begin
            wrapf_d = 1'b1;
        end
        wrap_d = wrap_evt;
    end

    // PWM compare; outputs freeze at their last value while disabled.
    always_comb begin
        pwm_d = pwm_q;
        if (en_q) begin
            for (int n = 0; n < NCH; n++) begin
                pwm_d[n] = (cnt_q < duty_act[n]);
            end
        end
    end

`ifdef PWM_SHADOW_EN
    logic [CW-1:0]            period_sh_q;
    logic [NCH-1:0][CW-1:0]   duty_sh_q;
    logic                     shadow_ld;

    // Reload at a cycle boundary so a duty/period change never splits a PWM cycle;
    // while stopped or on CLR the copies track the written registers freely.
    assign shadow_ld = wrap_evt | ~en_q | clr;

    // Shadow copies of PERIOD and DUTY feeding the comparators.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_sh_q <= '0;
            duty_sh_q   <= '0;
        end else if (shadow_ld) begin
            period_sh_q <= period_q;
            duty_sh_q   <= duty_q;
        end
    end

    assign period_act = period_sh_q;
    assign duty_act   = duty_sh_q;
`else
    // Without shadowing, writes take effect on the next clock.
    assign period_act = period_q;
    assign duty_act   = duty_q;
`endif

    // Read mux: combinational from addr, zero-extended, unmapped offsets read 0.
    always_comb begin
        dout = '0;
        case (addr)
            A_CTRL:   dout[0]      = en_q;
            A_PRESC:  dout[CW-1:0] = presc_q;
            A_PERIOD: dout[CW-1:0] = period_q;
            A_STATUS: dout[0]      = wrapf_q;
            default: begin
                for (int n = 0; n < NCH; n++) begin
                    if (addr == A_DUTY0 + 4'(n)) begin
                        dout[CW-1:0] = duty_q[n];
                    end
                end
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_q       <= 1'b0;
            en_q        <= 1'b0;
            presc_q     <= '0;
            period_q    <= '0;
            wrapf_q     <= 1'b0;
            duty_q      <= '0;
            presc_cnt_q <= '0;
            cnt_q       <= '0;
            pwm_q       <= '0;
            wrap_q      <= 1'b0;
        end else begin
            rdy_q       <= rdy_d;
            en_q        <= en_d;
            presc_q     <= presc_d;
            period_q    <= period_d;
            wrapf_q     <= wrapf_d;
            duty_q      <= duty_d;
            presc_cnt_q <= presc_cnt_d;
            cnt_q       <= cnt_d;
            pwm_q       <= pwm_d;
            wrap_q      <= wrap_d;
        end
    end

    assign rdy  = rdy_q;
    assign pwm  = pwm_q;
    assign wrap = wrap_q;

endmodule
